// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Controller FSM: normal issue, or holding E for a multi-cycle op.
    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } ctrl_state_t;

    // E-stage operand source select.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Legal multi-cycle latency range; the counter is sized for the maximum.
    localparam int MC_LATENCY_MIN = 2;
    localparam int MC_LATENCY_MAX = 15;
    localparam int MC_CNT_W       = 4;

    // Counter preload for the MC_BUSY phase. The RUN cycle that detects the op
    // already stalls once, so MC_BUSY runs for latency-1 cycles (load..0).
    // Out-of-range latencies are clamped into the legal range.
    function automatic logic [MC_CNT_W-1:0] mc_count_load(input int latency);
        int lat;
        lat = latency;
        if (lat < MC_LATENCY_MIN) lat = MC_LATENCY_MIN;
        if (lat > MC_LATENCY_MAX) lat = MC_LATENCY_MAX;
        return MC_CNT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one E-stage source operand.
// M has priority over W (it holds the younger result); register 0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic              reg_write_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              reg_write_w_i,
    output fwd_sel_t          fwd_o
);

    // Pick the youngest in-flight producer of rs_i, else the register file.
    always_comb begin
        // NOTE: default first so every path assigns fwd_o and no latch is inferred.
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush
// controls for F/D, D/E, E/M and the E-stage forwarding selects.
// Only the FSM state and latency counter are registered; all outputs are
// combinational so they land in the same cycle as the hazard.
// Optional: define HAZARD_PERF_EN to build the StallCnt/FlushCnt counters;
// otherwise both are tied to zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              MemToRegE,
    input  logic              MultiCycleE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    localparam logic [MC_CNT_W-1:0] MC_LOAD = mc_count_load(MC_LATENCY);

    ctrl_state_t         state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    fwd_sel_t            fwd_a, fwd_b;
    logic                load_use;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_a)
    );

    fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .reg_write_m_i (RegWriteM),
        .rd_w_i        (RdW),
        .reg_write_w_i (RegWriteW),
        .fwd_o         (fwd_b)
    );

    // Forwards are forced to the register file while the pipeline is in reset.
    assign ForwardAE = RST ? FWD_RF : fwd_a;
    assign ForwardBE = RST ? FWD_RF : fwd_b;

    // A load in E whose destination is read by the instruction in D.
    assign load_use = MemToRegE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // State register and latency counter; reset aborts any multi-cycle op.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a multi-cycle op in RUN (not overridden by a branch) enters MC_BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (!PCSrcE && MultiCycleE) begin
                    state_d = MC_BUSY;
                    cnt_d   = MC_LOAD;
                end
            end
            MC_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - MC_CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall/flush outputs: reset, then MC_BUSY hold, then RUN priority order.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (RST) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else if (state_q == MC_BUSY) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (MultiCycleE) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Performance counters: stalled-decode cycles and E-flush cycles, wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallD) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (FlushE) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule
